// File: rtl/captura_pkg.sv
// Shared types and default widths for the operand/opcode capture block.
package captura_pkg;

   localparam int unsigned DefInLength  = 16;
   localparam int unsigned DefNOperands = 2;
   localparam int unsigned DefOpLength  = 2;

   // Capture FSM states; encoding 3 is unused and recovers as a clear.
   typedef enum logic [1:0] {
      S_OPERAND = 2'd0,
      S_OPCODE  = 2'd1,
      S_DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector with asynchronous active-high reset.
// RstVal sets the sampled level after reset; 1 suppresses an event for a
// level already high when reset is released.
module edge_rise #(
   parameter bit RstVal = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic rise_o
);

   logic d_q;

   // Sample the input level every cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         d_q <= RstVal;
      end else begin
         d_q <= d_i;
      end
   end

   assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/captura_operandos.sv
// Operand/opcode capture register for the calculator front end.
// Captures N_OPERANDS operands then one opcode from IN on rising edges of LOAD.
// Optional feature: define CAPTURA_BACK_EN to let BACK undo the last capture.
module captura_operandos
   import captura_pkg::*;
#(
   parameter int unsigned IN_LENGTH  = DefInLength,
   parameter int unsigned N_OPERANDS = DefNOperands,
   parameter int unsigned OP_LENGTH  = DefOpLength,
   localparam int unsigned IdxW      = $clog2(N_OPERANDS + 1)
) (
   input  logic                            CLK,
   input  logic                            RESET,
   input  logic [IN_LENGTH-1:0]            IN,
   input  logic                            LOAD,
   input  logic                            BACK,
   input  logic                            CLEAR,
   output logic [N_OPERANDS*IN_LENGTH-1:0] OPERANDS_OUT,
   output logic [OP_LENGTH-1:0]            OP_OUT,
   output logic [1:0]                      STATE_OUT,
   output logic [IdxW-1:0]                 IDX_OUT,
   output logic                            DONE_OUT,
   output logic                            CAPTURE_PULSE
);

   state_t                 state_q, state_d;
   logic [IdxW-1:0]        idx_q, idx_d;
   logic [IN_LENGTH-1:0]   ops_q [N_OPERANDS];
   logic [IN_LENGTH-1:0]   ops_d [N_OPERANDS];
   logic [OP_LENGTH-1:0]   op_q, op_d;
   logic                   pulse_q, pulse_d;
   logic                   load_rise;
   logic                   state_ok;

   edge_rise #(
      .RstVal (1'b1)
   ) u_load_edge (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .d_i    (LOAD),
      .rise_o (load_rise)
   );

`ifdef CAPTURA_BACK_EN
   logic back_rise;

   edge_rise #(
      .RstVal (1'b1)
   ) u_back_edge (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .d_i    (BACK),
      .rise_o (back_rise)
   );
`else
   // BACK has no function in this build.
   logic unused_back;
   assign unused_back = BACK;
`endif

   assign state_ok = (state_q == S_OPERAND) || (state_q == S_OPCODE) || (state_q == S_DONE);

   // State and captured-data registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_OPERAND;
         idx_q   <= '0;
         op_q    <= '0;
         pulse_q <= 1'b0;
         for (int k = 0; k < N_OPERANDS; k++) begin
            ops_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         pulse_q <= pulse_d;
         for (int k = 0; k < N_OPERANDS; k++) begin
            ops_q[k] <= ops_d[k];
         end
      end
   end

   // Next-state: CLEAR beats undo beats load; a losing event is dropped.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      op_d    = op_q;
      pulse_d = 1'b0;
      for (int k = 0; k < N_OPERANDS; k++) begin
         ops_d[k] = ops_q[k];
      end

      if (CLEAR || !state_ok) begin
         state_d = S_OPERAND;
         idx_d   = '0;
         op_d    = '0;
         for (int k = 0; k < N_OPERANDS; k++) begin
            ops_d[k] = '0;
         end
      end
`ifdef CAPTURA_BACK_EN
      else if (back_rise) begin
         case (state_q)
            S_OPERAND: begin
               if (idx_q != '0) begin
                  for (int k = 0; k < N_OPERANDS; k++) begin
                     if (IdxW'(k + 1) == idx_q) begin
                        ops_d[k] = '0;
                     end
                  end
                  idx_d = idx_q - IdxW'(1);
               end
            end
            S_OPCODE: begin
               ops_d[N_OPERANDS-1] = '0;
               idx_d               = IdxW'(N_OPERANDS - 1);
               state_d             = S_OPERAND;
            end
            S_DONE: begin
               op_d    = '0;
               state_d = S_OPCODE;
            end
            default: ;
         endcase
      end
`endif
      else if (load_rise) begin
         pulse_d = 1'b1;
         case (state_q)
            S_OPERAND: begin
               for (int k = 0; k < N_OPERANDS; k++) begin
                  if (IdxW'(k) == idx_q) begin
                     ops_d[k] = IN;
                  end
               end
               if (idx_q < IdxW'(N_OPERANDS - 1)) begin
                  idx_d = idx_q + IdxW'(1);
               end else begin
                  idx_d   = IdxW'(N_OPERANDS);
                  state_d = S_OPCODE;
               end
            end
            S_OPCODE: begin
               op_d    = IN[OP_LENGTH-1:0];
               state_d = S_DONE;
            end
            S_DONE: begin
               // Start a new calculation with this value as operand 0.
               for (int k = 1; k < N_OPERANDS; k++) begin
                  ops_d[k] = '0;
               end
               ops_d[0] = IN;
               op_d     = '0;
               idx_d    = IdxW'(1);
               state_d  = (N_OPERANDS == 1) ? S_OPCODE : S_OPERAND;
            end
            default: pulse_d = 1'b0;
         endcase
      end
   end

   // Outputs are pure decodes of registered state.
   always_comb begin
      OPERANDS_OUT = '0;
      for (int k = 0; k < N_OPERANDS; k++) begin
         OPERANDS_OUT[k*IN_LENGTH +: IN_LENGTH] = ops_q[k];
      end
      OP_OUT        = op_q;
      STATE_OUT     = state_q;
      IDX_OUT       = idx_q;
      DONE_OUT      = (state_q == S_DONE);
      CAPTURE_PULSE = pulse_q;
   end

endmodule

// File: tb/tb_captura_operandos.sv
// Scoreboard bench for captura_operandos with default parameters.
module tb_captura_operandos;

   typedef struct packed {
      logic [31:0] ops;
      logic [1:0]  op;
      logic [1:0]  st;
      logic [1:0]  idx;
      logic        done;
   } snap_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] in_v = '0;
   logic        load = 1'b0;
   logic        back = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] ops_o;
   logic [1:0]  op_o;
   logic [1:0]  st_o;
   logic [1:0]  idx_o;
   logic        done_o;
   logic        pulse_o;

   int n_cmp = 0;
   int n_fail = 0;
   int pulses = 0;
   int p0;
   snap_t exp_q[$];

   captura_operandos dut (
      .CLK           (clk),
      .RESET         (rst),
      .IN            (in_v),
      .LOAD          (load),
      .BACK          (back),
      .CLEAR         (clear),
      .OPERANDS_OUT  (ops_o),
      .OP_OUT        (op_o),
      .STATE_OUT     (st_o),
      .IDX_OUT       (idx_o),
      .DONE_OUT      (done_o),
      .CAPTURE_PULSE (pulse_o)
   );

   always #5 clk = ~clk;

   function automatic snap_t mk(logic [31:0] ops, logic [1:0] op, logic [1:0] st,
                                logic [1:0] idx, logic done);
      snap_t s;
      s.ops = ops; s.op = op; s.st = st; s.idx = idx; s.done = done;
      return s;
   endfunction

   function automatic snap_t cur();
      return mk(ops_o, op_o, st_o, idx_o, done_o);
   endfunction

   task automatic cmp_snap(string name, snap_t act, snap_t req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got ops=%h op=%0d st=%0d idx=%0d done=%0d, want ops=%h op=%0d st=%0d idx=%0d done=%0d",
                  name, act.ops, act.op, act.st, act.idx, act.done,
                  req.ops, req.op, req.st, req.idx, req.done);
      end
   endtask

   task automatic cmp_int(string name, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   // Monitor: every capture pulse is matched against the next expectation.
   always @(negedge clk) begin
      if (!rst && pulse_o === 1'b1) begin
         pulses++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_pulse: got pulse with ops=%h st=%0d, want no pulse",
                     ops_o, st_o);
         end else begin
            cmp_snap("capture", cur(), exp_q.pop_front());
         end
      end
   end

   task automatic press(logic [15:0] v, snap_t e);
      @(negedge clk);
      in_v = v;
      load = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
   endtask

   task automatic press_back();
      @(negedge clk);
      back = 1'b1;
      @(negedge clk);
      back = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #1;
      cmp_snap("reset_state", cur(), mk(32'h0, 2'd0, 2'd0, 2'd0, 1'b0));
      cmp_int("reset_pulse", int'(pulse_o), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Basic sequence: two operands then the opcode.
      press(16'h1234, mk(32'h0000_1234, 2'd0, 2'd0, 2'd1, 1'b0));
      press(16'h00AB, mk(32'h00AB_1234, 2'd0, 2'd1, 2'd2, 1'b0));
      press(16'h0002, mk(32'h00AB_1234, 2'd2, 2'd2, 2'd2, 1'b1));
      cmp_int("three_pulses", pulses, 3);

      // New calculation from S_DONE.
      press(16'h0F0F, mk(32'h0000_0F0F, 2'd0, 2'd0, 2'd1, 1'b0));

      // Held LOAD gives one capture only.
      p0 = pulses;
      @(negedge clk);
      in_v = 16'h5555;
      load = 1'b1;
      exp_q.push_back(mk(32'h5555_0F0F, 2'd0, 2'd1, 2'd2, 1'b0));
      repeat (20) @(negedge clk);
      cmp_int("held_one_pulse", pulses - p0, 1);
      cmp_int("held_idx", int'(idx_o), 2);
      load = 1'b0;
      @(negedge clk);

      // CLEAR and LOAD rise together in S_OPCODE: CLEAR wins.
      p0 = pulses;
      in_v = 16'h0003;
      clear = 1'b1;
      load = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      load = 1'b0;
      cmp_snap("clear_wins", cur(), mk(32'h0, 2'd0, 2'd0, 2'd0, 1'b0));
      @(negedge clk);
      cmp_int("clear_no_pulse", pulses - p0, 0);
      press(16'h0077, mk(32'h0000_0077, 2'd0, 2'd0, 2'd1, 1'b0));

      // Undo sequence from S_OPCODE with operands 5 and 7.
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      press(16'h0005, mk(32'h0000_0005, 2'd0, 2'd0, 2'd1, 1'b0));
      press(16'h0007, mk(32'h0007_0005, 2'd0, 2'd1, 2'd2, 1'b0));
      p0 = pulses;
      press_back();
`ifdef CAPTURA_BACK_EN
      cmp_snap("back1", cur(), mk(32'h0000_0005, 2'd0, 2'd0, 2'd1, 1'b0));
`else
      cmp_snap("back1", cur(), mk(32'h0007_0005, 2'd0, 2'd1, 2'd2, 1'b0));
`endif
      press_back();
`ifdef CAPTURA_BACK_EN
      cmp_snap("back2", cur(), mk(32'h0, 2'd0, 2'd0, 2'd0, 1'b0));
`else
      cmp_snap("back2", cur(), mk(32'h0007_0005, 2'd0, 2'd1, 2'd2, 1'b0));
`endif
      press_back();
`ifdef CAPTURA_BACK_EN
      cmp_snap("back3", cur(), mk(32'h0, 2'd0, 2'd0, 2'd0, 1'b0));
`else
      cmp_snap("back3", cur(), mk(32'h0007_0005, 2'd0, 2'd1, 2'd2, 1'b0));
`endif
      cmp_int("back_no_pulse", pulses - p0, 0);

      // Asynchronous reset mid-sequence with LOAD held across release.
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      press(16'h0AAA, mk(32'h0000_0AAA, 2'd0, 2'd0, 2'd1, 1'b0));
      @(posedge clk);
      #3;
      rst = 1'b1;
      load = 1'b1;
      in_v = 16'h0CCC;
      #1;
      cmp_snap("async_reset", cur(), mk(32'h0, 2'd0, 2'd0, 2'd0, 1'b0));
      @(negedge clk);
      #2;
      rst = 1'b0;
      p0 = pulses;
      repeat (5) @(negedge clk);
      cmp_snap("held_through_reset", cur(), mk(32'h0, 2'd0, 2'd0, 2'd0, 1'b0));
      cmp_int("held_reset_no_pulse", pulses - p0, 0);
      load = 1'b0;
      @(negedge clk);
      press(16'h0BBB, mk(32'h0000_0BBB, 2'd0, 2'd0, 2'd1, 1'b0));

      repeat (3) @(negedge clk);
      cmp_int("pending_expectations", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
